legv8_microsequencer: RTL and testbench
=======================================

# legv8_microsequencer

Multi-cycle control sequencer for the LEGv8 datapath-with-memory. It accepts one decoded operation per valid/ready handshake and drives the datapath's 32-bit control word and 64-bit constant for each step. ALU operations take one step. Loads and stores take two steps: first an address computation into a scratch register, then the memory access. It sits between the instruction decoder and the datapath and replaces hand-driven control words.

## Interface
Parameters:
- SCRATCH_REG, default 5'd7: register that receives the computed memory address.
- ZERO_REG, default 5'd31: register that reads as zero, used as the don't-care source.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  reset; synchronous and active-high
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept a request this cycle
- req_op  in  3  operation: 000 NOP, 001 ALU_R, 010 ALU_I, 011 LOAD, 100 STORE; 101–111 illegal
- req_fs  in  5  ALU function select (ALU ops only)
- req_c0  in  1  ALU carry-in (ALU ops only)
- req_rd  in  5  destination register; for STORE, the data register Rt
- req_rn  in  5  first source / base register
- req_rm  in  5  second source register (ALU_R only)
- req_imm  in  64  immediate or offset
- req_setflags  in  1  latch the status flags at the end of an ALU op
- status  in  4  datapath status {V,C,N,Z}
- control_word  out  32  datapath control word, registered
- constant  out  64  datapath constant, registered
- busy  out  1  sequencer not in IDLE
- done  out  1  one-cycle pulse that coincides with the final step of an op
- illegal  out  1  one-cycle pulse when an illegal op is accepted
- flags  out  4  latched {V,C,N,Z}; present only with USEQ_FLAGS_EN

## Operation
Control word layout (decided):
- DA [4:0], SA [9:5], SB [14:10]
- RW [15], BS [16] (constant as B operand), FS [21:17], C0 [22]
- EN_B [23], EN_ALU [24], MW [25], EN_MEM [26]
- SIZE [28:27] (11 = doubleword), SRC [31:29]: 001 = store, 010 = load

NOP word: all zeros.

States: IDLE, EXEC, ADDR, MEM.
- IDLE: outputs the NOP word.
- An accepted op selects the next state:
  - ALU_R / ALU_I → EXEC
  - LOAD / STORE → ADDR
  - NOP / illegal → IDLE (illegal also pulses illegal)
- EXEC: DA=rd, SA=rn, SB=rm, RW=1, EN_ALU=1, FS/C0 from the request. ALU_I sets BS=1 and constant=imm.
- ADDR: DA=SCRATCH_REG, SA=rn, BS=1, FS=01000 (ADD), C0=0, RW=1, EN_ALU=1, constant=imm.
- MEM, LOAD: SA=SCRATCH_REG, DA=rd, SB=ZERO_REG, RW=1, EN_MEM=1, EN_B=1, FS=00100, SIZE=11, SRC=010.
- MEM, STORE: SA=SCRATCH_REG, SB=rd, MW=1, RW=0, EN_MEM=1, EN_B=1, FS=00100, SIZE=11, SRC=001.
- After EXEC or MEM, the state becomes the next accepted op's first state, or IDLE if none is accepted.
- Request fields are captured in a holding register at acceptance. They must not be sampled again after acceptance.

## Timing
- Reset values: state=IDLE, control_word=0, constant=0, done=0, illegal=0, busy=0, flags=0.
- req_ready = (state==IDLE) | (state==EXEC) | (state==MEM), and is forced 0 while reset is high.
- A request is accepted at the rising edge where req_valid & req_ready.
- Accepted at edge N: the first-step control word is valid from edge N to edge N+1.
  - ALU op: 1 cycle of control.
  - LOAD/STORE: 2 consecutive cycles (ADDR, then MEM).
- Back-to-back ops issue with no bubble between them.
- done is high in the cycle the EXEC or MEM word is driven.
- flags update at the edge that ends EXEC, and only when setflags was captured. Flags sample status at that edge.
- Reset asserted mid-operation aborts the op. The NOP word is output from the next edge, with no done pulse.
- req_valid low while the sequencer is ready: remain in IDLE, or return to IDLE after the final step.
- SCRATCH_REG used as rd or rn is not detected. The sequence executes as specified and the result is software's responsibility.

## Configuration
- USEQ_FLAGS_EN defined: the flags port and flag register exist and behave as in Timing.
- USEQ_FLAGS_EN undefined: the flags port is removed, req_setflags is ignored, and there is no flag register.

## Test plan
- Reset held 2 cycles, then released with req_valid=0 → control_word=0, req_ready=1, busy=0, done=0.
- ALU_I rd=0, rn=31, fs=00100, imm=24 → next cycle control_word=32'b000_00_0_0_1_0_0_00100_1_1_00000_11111_00000 (SB=0), constant=24, done=1, then IDLE.
- STORE rd=1, rn=31, imm=24 → cycle 1: DA=7, SA=31, BS=1, FS=01000, RW=1, constant=24; cycle 2: MW=1, SA=7, SB=1, RW=0, SRC=001, done=1; req_ready=0 during cycle 1.
- LOAD rd=2 issued back-to-back after an ALU_R (rd=1, rn=0, rm=1, fs=00000) → EXEC, ADDR, MEM in 3 consecutive cycles with no NOP between them; the LOAD MEM word has DA=2, RW=1, SRC=010.
- req_op=110 → illegal pulse for 1 cycle, control_word stays 0, done=0.
- Reset asserted during a LOAD's ADDR cycle → NOP word from the next cycle, no done pulse. With USEQ_FLAGS_EN: ALU op with setflags=1 and status=4'b0101 → flags=4'b0101 after EXEC.

Source files
------------

// File: rtl/legv8_microsequencer.sv
// ============================================================================
//  Module   : legv8_microsequencer
//  Purpose  : Multi-cycle control sequencer for the LEGv8 datapath with
//             memory. Accepts one decoded operation per valid/ready handshake
//             and drives a registered 32-bit control word and 64-bit constant
//             for each step: ALU ops take one step, loads/stores take two
//             (address into a scratch register, then the memory access).
//  Options  : USEQ_FLAGS_EN - adds the latched {V,C,N,Z} flag register and
//             the flags output port.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module legv8_microsequencer #(
  parameter logic [4:0] SCRATCH_REG = 5'd7,
  parameter logic [4:0] ZERO_REG    = 5'd31
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [4:0]  req_fs,
  input  logic        req_c0,
  input  logic [4:0]  req_rd,
  input  logic [4:0]  req_rn,
  input  logic [4:0]  req_rm,
  input  logic [63:0] req_imm,
  input  logic        req_setflags,
  input  logic [3:0]  status,
  output logic [31:0] control_word,
  output logic [63:0] constant,
  output logic        busy,
  output logic        done,
  output logic        illegal
`ifdef USEQ_FLAGS_EN
  ,
  output logic [3:0]  flags
`endif
);

  // Operation encodings presented by the decoder
  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_ALU_R = 3'b001;
  localparam logic [2:0] OP_ALU_I = 3'b010;
  localparam logic [2:0] OP_LOAD  = 3'b011;
  localparam logic [2:0] OP_STORE = 3'b100;

  // Fixed datapath function selects used by the memory sequence
  localparam logic [4:0] FS_ADD   = 5'b01000;
  localparam logic [4:0] FS_PASSB = 5'b00100;
  localparam logic [1:0] SIZE_DW  = 2'b11;
  localparam logic [2:0] SRC_NONE = 3'b000;
  localparam logic [2:0] SRC_ST   = 3'b001;
  localparam logic [2:0] SRC_LD   = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_ADDR = 2'd2,
    ST_MEM  = 2'd3
  } state_t;

  state_t      state, state_next;
  logic [31:0] cw_next;
  logic [63:0] const_next;
  logic        done_next;
  logic        illegal_next;
  logic        accept;

  // Fields still needed after the first step of a load/store
  logic [4:0]  hold_rd, hold_rd_next;
  logic        hold_store, hold_store_next;
  logic        hold_setflags, hold_setflags_next;

  // Assemble a control word from its named fields
  function automatic logic [31:0] pack_cw(
    input logic [4:0] da,
    input logic [4:0] sa,
    input logic [4:0] sb,
    input logic       rw,
    input logic       bs,
    input logic [4:0] fs,
    input logic       c0,
    input logic       en_b,
    input logic       en_alu,
    input logic       mw,
    input logic       en_mem,
    input logic [1:0] size,
    input logic [2:0] src
  );
    return {src, size, en_mem, mw, en_alu, en_b, c0, fs, bs, rw, sb, sa, da};
  endfunction

  // The only step that cannot take a new request is ADDR; reset blocks intake
  assign req_ready = ~reset & (state != ST_ADDR);
  assign accept    = req_valid & req_ready;
  assign busy      = (state != ST_IDLE);

  // Next state and next registered outputs
  always_comb begin
    state_next         = ST_IDLE;
    cw_next            = 32'd0;
    const_next         = 64'd0;
    done_next          = 1'b0;
    illegal_next       = 1'b0;
    hold_rd_next       = hold_rd;
    hold_store_next    = hold_store;
    hold_setflags_next = 1'b0;

    if (accept) begin
      case (req_op)
        OP_ALU_R: begin
          state_next         = ST_EXEC;
          done_next          = 1'b1;
          hold_setflags_next = req_setflags;
          cw_next = pack_cw(req_rd, req_rn, req_rm, 1'b1, 1'b0, req_fs, req_c0,
                            1'b0, 1'b1, 1'b0, 1'b0, 2'b00, SRC_NONE);
        end
        OP_ALU_I: begin
          state_next         = ST_EXEC;
          done_next          = 1'b1;
          hold_setflags_next = req_setflags;
          const_next         = req_imm;
          cw_next = pack_cw(req_rd, req_rn, 5'd0, 1'b1, 1'b1, req_fs, req_c0,
                            1'b0, 1'b1, 1'b0, 1'b0, 2'b00, SRC_NONE);
        end
        OP_LOAD, OP_STORE: begin
          // Address step: SCRATCH_REG <= Rn + imm
          state_next      = ST_ADDR;
          const_next      = req_imm;
          hold_rd_next    = req_rd;
          hold_store_next = (req_op == OP_STORE);
          cw_next = pack_cw(SCRATCH_REG, req_rn, 5'd0, 1'b1, 1'b1, FS_ADD, 1'b0,
                            1'b0, 1'b1, 1'b0, 1'b0, 2'b00, SRC_NONE);
        end
        OP_NOP: begin
          state_next = ST_IDLE;
        end
        default: begin
          state_next   = ST_IDLE;
          illegal_next = 1'b1;
        end
      endcase
    end else if (state == ST_ADDR) begin
      // Memory step uses only the captured fields, never the live request
      state_next = ST_MEM;
      done_next  = 1'b1;
      if (hold_store) begin
        cw_next = pack_cw(5'd0, SCRATCH_REG, hold_rd, 1'b0, 1'b0, FS_PASSB, 1'b0,
                          1'b1, 1'b0, 1'b1, 1'b1, SIZE_DW, SRC_ST);
      end else begin
        cw_next = pack_cw(hold_rd, SCRATCH_REG, ZERO_REG, 1'b1, 1'b0, FS_PASSB, 1'b0,
                          1'b1, 1'b0, 1'b0, 1'b1, SIZE_DW, SRC_LD);
      end
    end
  end

  // State, holding register and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= ST_IDLE;
      control_word  <= 32'd0;
      constant      <= 64'd0;
      done          <= 1'b0;
      illegal       <= 1'b0;
      hold_rd       <= 5'd0;
      hold_store    <= 1'b0;
      hold_setflags <= 1'b0;
    end else begin
      state         <= state_next;
      control_word  <= cw_next;
      constant      <= const_next;
      done          <= done_next;
      illegal       <= illegal_next;
      hold_rd       <= hold_rd_next;
      hold_store    <= hold_store_next;
      hold_setflags <= hold_setflags_next;
    end
  end

`ifdef USEQ_FLAGS_EN
  // Status is latched at the edge that ends an EXEC step which asked for it
  always_ff @(posedge clock) begin
    if (reset) begin
      flags <= 4'd0;
    end else if ((state == ST_EXEC) && hold_setflags) begin
      flags <= status;
    end
  end
`else
  // Without the flag register the setflags request and status are ignored
  logic unused_flag_inputs;
  assign unused_flag_inputs = &{1'b0, status, hold_setflags};
`endif

endmodule

`default_nettype wire

// File: tb/tb_legv8_microsequencer.sv
// ============================================================================
//  Module   : tb_legv8_microsequencer
//  Purpose  : Directed self-checking bench for legv8_microsequencer.
//             Inputs change and outputs are sampled on the falling edge.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_legv8_microsequencer;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [4:0]  req_fs;
  logic        req_c0;
  logic [4:0]  req_rd;
  logic [4:0]  req_rn;
  logic [4:0]  req_rm;
  logic [63:0] req_imm;
  logic        req_setflags;
  logic [3:0]  status;
  logic [31:0] control_word;
  logic [63:0] constant;
  logic        busy;
  logic        done;
  logic        illegal;
`ifdef USEQ_FLAGS_EN
  logic [3:0]  flags;
`endif

  int checks = 0;
  int errors = 0;

  // Hand-computed control words
  localparam logic [31:0] CW_ALU_I   = 32'h010983E0; // rd0 rn31 fs00100 BS
  localparam logic [31:0] CW_ST_ADDR = 32'h011183E7; // DA7 SA31 ADD BS
  localparam logic [31:0] CW_ST_MEM  = 32'h3E8804E0; // SA7 SB1 MW SRC001
  localparam logic [31:0] CW_ALU_R   = 32'h01008401; // rd1 rn0 rm1 fs0
  localparam logic [31:0] CW_LD_ADDR = 32'h01118067; // DA7 SA3 ADD BS
  localparam logic [31:0] CW_LD_MEM  = 32'h5C88FCE2; // DA2 SA7 SB31 SRC010

  legv8_microsequencer dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_fs       (req_fs),
    .req_c0       (req_c0),
    .req_rd       (req_rd),
    .req_rn       (req_rn),
    .req_rm       (req_rm),
    .req_imm      (req_imm),
    .req_setflags (req_setflags),
    .status       (status),
    .control_word (control_word),
    .constant     (constant),
    .busy         (busy),
    .done         (done),
    .illegal      (illegal)
`ifdef USEQ_FLAGS_EN
    ,
    .flags        (flags)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic drive_req(input logic [2:0] op, input logic [4:0] fs, input logic c0,
                           input logic [4:0] rd, input logic [4:0] rn, input logic [4:0] rm,
                           input logic [63:0] imm, input logic sf);
    req_valid    = 1'b1;
    req_op       = op;
    req_fs       = fs;
    req_c0       = c0;
    req_rd       = rd;
    req_rn       = rn;
    req_rm       = rm;
    req_imm      = imm;
    req_setflags = sf;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = 1'b0;
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    checks++;
    if (req_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready_low: got %b expected 0", req_ready);
    end
    reset = 1'b0;
    @(posedge clock);
    @(negedge clock);
    checks++;
    if (control_word !== 32'd0 || constant !== 64'd0) begin
      errors++; $display("FAIL reset_words: got cw=%h k=%h expected 0/0", control_word, constant);
    end
    checks++;
    if ({req_ready, busy, done, illegal} !== 4'b1000) begin
      errors++; $display("FAIL reset_status: got rdy/busy/done/ill=%b expected 1000",
                         {req_ready, busy, done, illegal});
    end
  endtask

  task automatic test_alu_i();
    drive_req(3'b010, 5'b00100, 1'b0, 5'd0, 5'd31, 5'd0, 64'd24, 1'b0);
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    checks++;
    if (control_word !== CW_ALU_I || constant !== 64'd24) begin
      errors++; $display("FAIL alu_i_word: got cw=%h k=%0d expected %h k=24",
                         control_word, constant, CW_ALU_I);
    end
    checks++;
    if ({done, busy} !== 2'b11) begin
      errors++; $display("FAIL alu_i_done: got done/busy=%b expected 11", {done, busy});
    end
    @(negedge clock);
    checks++;
    if (control_word !== 32'd0 || {done, busy} !== 2'b00) begin
      errors++; $display("FAIL alu_i_idle: got cw=%h done/busy=%b expected 0 00",
                         control_word, {done, busy});
    end
  endtask

  task automatic test_store();
    drive_req(3'b100, 5'b00000, 1'b0, 5'd1, 5'd31, 5'd0, 64'd24, 1'b0);
    @(posedge clock);
    @(negedge clock);
    // Disturb the request fields; the memory step must use captured values
    req_valid = 1'b0;
    req_rd    = 5'd9;
    req_rn    = 5'd4;
    checks++;
    if (control_word !== CW_ST_ADDR || constant !== 64'd24) begin
      errors++; $display("FAIL store_addr: got cw=%h k=%0d expected %h k=24",
                         control_word, constant, CW_ST_ADDR);
    end
    checks++;
    if ({req_ready, done, busy} !== 3'b001) begin
      errors++; $display("FAIL store_addr_hs: got rdy/done/busy=%b expected 001",
                         {req_ready, done, busy});
    end
    @(negedge clock);
    checks++;
    if (control_word !== CW_ST_MEM || constant !== 64'd0) begin
      errors++; $display("FAIL store_mem: got cw=%h k=%0d expected %h k=0",
                         control_word, constant, CW_ST_MEM);
    end
    checks++;
    if ({req_ready, done} !== 2'b11) begin
      errors++; $display("FAIL store_mem_done: got rdy/done=%b expected 11", {req_ready, done});
    end
    @(negedge clock);
    checks++;
    if (control_word !== 32'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL store_idle: got cw=%h busy=%b expected 0 0", control_word, busy);
    end
  endtask

  task automatic test_back_to_back();
    drive_req(3'b001, 5'b00000, 1'b0, 5'd1, 5'd0, 5'd1, 64'd0, 1'b0);
    @(posedge clock);
    @(negedge clock);
    checks++;
    if (control_word !== CW_ALU_R || done !== 1'b1) begin
      errors++; $display("FAIL b2b_alu_r: got cw=%h done=%b expected %h 1",
                         control_word, done, CW_ALU_R);
    end
    drive_req(3'b011, 5'b00000, 1'b0, 5'd2, 5'd3, 5'd0, 64'd16, 1'b0);
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    checks++;
    if (control_word !== CW_LD_ADDR || constant !== 64'd16 || done !== 1'b0) begin
      errors++; $display("FAIL b2b_ld_addr: got cw=%h k=%0d done=%b expected %h 16 0",
                         control_word, constant, done, CW_LD_ADDR);
    end
    @(negedge clock);
    checks++;
    if (control_word !== CW_LD_MEM || done !== 1'b1) begin
      errors++; $display("FAIL b2b_ld_mem: got cw=%h done=%b expected %h 1",
                         control_word, done, CW_LD_MEM);
    end
    @(negedge clock);
    checks++;
    if (control_word !== 32'd0 || done !== 1'b0) begin
      errors++; $display("FAIL b2b_idle: got cw=%h done=%b expected 0 0", control_word, done);
    end
  endtask

  task automatic test_illegal();
    drive_req(3'b110, 5'b00000, 1'b0, 5'd3, 5'd3, 5'd3, 64'd5, 1'b0);
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    checks++;
    if ({illegal, done, busy} !== 3'b100 || control_word !== 32'd0) begin
      errors++; $display("FAIL illegal_pulse: got ill/done/busy=%b cw=%h expected 100 0",
                         {illegal, done, busy}, control_word);
    end
    @(negedge clock);
    checks++;
    if (illegal !== 1'b0) begin
      errors++; $display("FAIL illegal_one_cycle: got %b expected 0", illegal);
    end
  endtask

  task automatic test_reset_abort();
    drive_req(3'b011, 5'b00000, 1'b0, 5'd2, 5'd3, 5'd0, 64'd16, 1'b0);
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    checks++;
    if (control_word !== CW_LD_ADDR) begin
      errors++; $display("FAIL abort_addr: got cw=%h expected %h", control_word, CW_LD_ADDR);
    end
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    checks++;
    if (control_word !== 32'd0 || {done, busy, req_ready} !== 3'b000) begin
      errors++; $display("FAIL abort_nop: got cw=%h done/busy/rdy=%b expected 0 000",
                         control_word, {done, busy, req_ready});
    end
    reset = 1'b0;
    @(posedge clock);
    @(negedge clock);
    checks++;
    if (control_word !== 32'd0 || done !== 1'b0) begin
      errors++; $display("FAIL abort_no_mem: got cw=%h done=%b expected 0 0", control_word, done);
    end
  endtask

`ifdef USEQ_FLAGS_EN
  task automatic test_flags();
    checks++;
    if (flags !== 4'b0000) begin
      errors++; $display("FAIL flags_reset: got %b expected 0000", flags);
    end
    status = 4'b0101;
    drive_req(3'b001, 5'b00000, 1'b0, 5'd1, 5'd0, 5'd1, 64'd0, 1'b1);
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    checks++;
    if (flags !== 4'b0000) begin
      errors++; $display("FAIL flags_during_exec: got %b expected 0000", flags);
    end
    @(posedge clock);
    @(negedge clock);
    status = 4'b1010;
    checks++;
    if (flags !== 4'b0101) begin
      errors++; $display("FAIL flags_latched: got %b expected 0101", flags);
    end
    drive_req(3'b001, 5'b00000, 1'b0, 5'd1, 5'd0, 5'd1, 64'd0, 1'b0);
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    @(posedge clock);
    @(negedge clock);
    checks++;
    if (flags !== 4'b0101) begin
      errors++; $display("FAIL flags_hold: got %b expected 0101", flags);
    end
  endtask
`endif

  initial begin
    reset        = 1'b1;
    req_valid    = 1'b0;
    req_op       = 3'b000;
    req_fs       = 5'd0;
    req_c0       = 1'b0;
    req_rd       = 5'd0;
    req_rn       = 5'd0;
    req_rm       = 5'd0;
    req_imm      = 64'd0;
    req_setflags = 1'b0;
    status       = 4'b0000;
    @(negedge clock);
    test_reset();
    test_alu_i();
    test_store();
    test_back_to_back();
    test_illegal();
    test_reset_abort();
`ifdef USEQ_FLAGS_EN
    test_flags();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
